cuasi_result_checker: RTL and testbench

Sequential result checker that sits on the output side of the 4-bit cuasi ALU (sel=0 → add, sel=1 → AND).
- Accepts one {a, b, sel, c} vector per valid/ready handshake.
- Recomputes the expected result and counts passes and mismatches.
- Captures the first failing vector.
- Reports done/pass after a fixed number of vectors.
- Hardware counterpart of the stimulus side; used for self-checking on FPGA and in simulation.

---
 rtl/cuasi_result_checker.sv | 242 ++++++++++++++++++++++++
 tb/tb_cuasi_result_checker.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cuasi_result_checker.sv
// cuasi_result_checker: output-side checker for the 4-bit cuasi ALU.
// Takes one {a, b, sel, c} vector per valid/ready handshake and recomputes
// the expected result (sel=0: a+b with the carry dropped, sel=1: a&b).
// It counts passes and mismatches and keeps the first failing vector.
// After NUM_VEC vectors it raises done and pass.
// Optional build macro CUASI_CARRY_CHECK_EN:
//   adds a cout input that is checked against the carry of a+b, and must be
//   0 for AND. cout becomes the LSB of the captured first-error vector.
// NUM_VEC must lie in 1 .. 2**CNT_W-1.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset; waits for start; in_ready=0
// S_RUN   | in_ready=1; accepts vectors until NUM_VEC have been taken
// S_DRAIN | in_ready=0; last registered vector is compared this cycle
// S_DONE  | done=1 and pass valid; waits for start to rerun

`timescale 1ns/1ps

module cuasi_result_checker #(
    parameter int WIDTH   = 4,
    parameter int NUM_VEC = 10,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sel,
    input  logic [WIDTH-1:0]     c,
`ifdef CUASI_CARRY_CHECK_EN
    input  logic                 cout,
`endif
    output logic                 chk_valid,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 first_err_valid,
`ifdef CUASI_CARRY_CHECK_EN
    output logic [3*WIDTH+1:0]   first_err_vec,
`else
    output logic [3*WIDTH:0]     first_err_vec,
`endif
    output logic [WIDTH-1:0]     first_err_exp,
    output logic                 done,
    output logic                 pass
);

`ifdef CUASI_CARRY_CHECK_EN
    localparam int C_LSB = 1;
`else
    localparam int C_LSB = 0;
`endif
    localparam int VEC_W = 3*WIDTH + 1 + C_LSB;
    localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               vec_vld_q, vec_vld_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               chk_valid_q, chk_valid_d;
    logic               mismatch_q, mismatch_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               ferr_vld_q, ferr_vld_d;
    logic [VEC_W-1:0]   ferr_vec_q, ferr_vec_d;
    logic [WIDTH-1:0]   ferr_exp_q, ferr_exp_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               accept;
    logic [VEC_W-1:0]   in_vec;

    logic [WIDTH-1:0]   r_a, r_b, r_c;
    logic               r_sel;
    logic [WIDTH:0]     sum_full;
    logic [WIDTH-1:0]   exp_res;
    logic               cmp_bad;

    logic [CNT_W-1:0]   pass_cnt_upd, err_cnt_upd;
    logic               ferr_vld_upd;
    logic [VEC_W-1:0]   ferr_vec_upd;
    logic [WIDTH-1:0]   ferr_exp_upd;

    assign in_ready = (state_q == S_RUN);
    assign accept   = in_ready & in_valid;

`ifdef CUASI_CARRY_CHECK_EN
    logic r_cout;
    assign in_vec = {a, b, sel, c, cout};
    assign r_cout = vec_q[0];
`else
    assign in_vec = {a, b, sel, c};
`endif

    // The captured vector uses the same field order as first_err_vec.
    assign r_c   = vec_q[C_LSB +: WIDTH];
    assign r_sel = vec_q[C_LSB + WIDTH];
    assign r_b   = vec_q[C_LSB + WIDTH + 1 +: WIDTH];
    assign r_a   = vec_q[C_LSB + 2*WIDTH + 1 +: WIDTH];

    // Reference result for the registered vector; the carry goes to a spare bit.
    always_comb begin
        sum_full = {1'b0, r_a} + {1'b0, r_b};
        exp_res  = r_sel ? (r_a & r_b) : sum_full[WIDTH-1:0];
        cmp_bad  = (r_c != exp_res);
`ifdef CUASI_CARRY_CHECK_EN
        cmp_bad  = cmp_bad | (r_cout != (r_sel ? 1'b0 : sum_full[WIDTH]));
`endif
    end

    // Commit the pending compare: pulse chk_valid, bump counters, capture the first error.
    always_comb begin
        chk_valid_d  = 1'b0;
        mismatch_d   = 1'b0;
        pass_cnt_upd = pass_cnt_q;
        err_cnt_upd  = err_cnt_q;
        ferr_vld_upd = ferr_vld_q;
        ferr_vec_upd = ferr_vec_q;
        ferr_exp_upd = ferr_exp_q;
        if (vec_vld_q) begin
            chk_valid_d = 1'b1;
            mismatch_d  = cmp_bad;
            if (cmp_bad) begin
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_upd = err_cnt_q + CNT_ONE;
                end
                if (!ferr_vld_q) begin
                    ferr_vld_upd = 1'b1;
                    ferr_vec_upd = vec_q;
                    ferr_exp_upd = exp_res;
                end
            end else if (pass_cnt_q < NUM_VEC_C) begin
                pass_cnt_upd = pass_cnt_q + CNT_ONE;
            end
        end
    end

    // Next-state logic; start clears the run results in the same edge it leaves IDLE/DONE.
    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        vec_vld_d  = accept;
        vec_d      = accept ? in_vec : vec_q;
        pass_cnt_d = pass_cnt_upd;
        err_cnt_d  = err_cnt_upd;
        ferr_vld_d = ferr_vld_upd;
        ferr_vec_d = ferr_vec_upd;
        ferr_exp_d = ferr_exp_upd;
        done_d     = done_q;
        pass_d     = pass_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    acc_cnt_d  = '0;
                    pass_cnt_d = '0;
                    err_cnt_d  = '0;
                    ferr_vld_d = 1'b0;
                    ferr_vec_d = '0;
                    ferr_exp_d = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_ONE;
                    if ((acc_cnt_q + CNT_ONE) >= NUM_VEC_C) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The final compare commits this cycle, so pass looks at the updated count.
                state_d = S_DONE;
                done_d  = 1'b1;
                pass_d  = (err_cnt_upd == '0);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_cnt_q   <= '0;
            vec_vld_q   <= 1'b0;
            vec_q       <= '0;
            chk_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            pass_cnt_q  <= '0;
            err_cnt_q   <= '0;
            ferr_vld_q  <= 1'b0;
            ferr_vec_q  <= '0;
            ferr_exp_q  <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            vec_vld_q   <= vec_vld_d;
            vec_q       <= vec_d;
            chk_valid_q <= chk_valid_d;
            mismatch_q  <= mismatch_d;
            pass_cnt_q  <= pass_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ferr_vld_q  <= ferr_vld_d;
            ferr_vec_q  <= ferr_vec_d;
            ferr_exp_q  <= ferr_exp_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign chk_valid       = chk_valid_q;
    assign mismatch        = mismatch_q;
    assign pass_count      = pass_cnt_q;
    assign err_count       = err_cnt_q;
    assign first_err_valid = ferr_vld_q;
    assign first_err_vec   = ferr_vec_q;
    assign first_err_exp   = ferr_exp_q;
    assign done            = done_q;
    assign pass            = pass_q;

endmodule

// File: tb/tb_cuasi_result_checker.sv
// Scoreboard bench for cuasi_result_checker.
// The driver pushes a hand-computed mismatch flag for each accepted vector.
// The monitor pops it on chk_valid and checks the flag, the latency and the running counters.

`timescale 1ns/1ps

module tb_cuasi_result_checker;

    localparam int W  = 4;
    localparam int NV = 10;
    localparam int CW = 8;
`ifdef CUASI_CARRY_CHECK_EN
    localparam int VW = 3*W + 2;
`else
    localparam int VW = 3*W + 1;
`endif

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       sel;
        logic [3:0] c;
        logic       bad;
    } vec_t;

    typedef struct {
        logic bad;
        int   due;
    } sb_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, sel = 1'b0;
    logic [W-1:0] a = '0, b = '0, c = '0;
    logic in_ready, chk_valid, mismatch, first_err_valid, done, pass;
    logic [CW-1:0] pass_count, err_count;
    logic [VW-1:0] first_err_vec;
    logic [W-1:0]  first_err_exp;

    logic s_start = 1'b0, s_in_valid = 1'b0, s_sel = 1'b0;
    logic [W-1:0] s_a = '0, s_b = '0, s_c = '0;
    logic s_in_ready, s_chk_valid, s_mismatch, s_first_err_valid, s_done, s_pass;
    logic [2:0] s_pass_count, s_err_count;
    logic [VW-1:0] s_first_err_vec;
    logic [W-1:0]  s_first_err_exp;

`ifdef CUASI_CARRY_CHECK_EN
    logic cout, s_cout;
    logic [W:0] sum5, s_sum5;
    assign sum5   = {1'b0, a} + {1'b0, b};
    assign s_sum5 = {1'b0, s_a} + {1'b0, s_b};
    assign cout   = sel ? 1'b0 : sum5[W];
    assign s_cout = s_sel ? 1'b0 : s_sum5[W];
`endif

    cuasi_result_checker #(.WIDTH(W), .NUM_VEC(NV), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .c(c),
`ifdef CUASI_CARRY_CHECK_EN
        .cout(cout),
`endif
        .chk_valid(chk_valid), .mismatch(mismatch), .pass_count(pass_count),
        .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_vec(first_err_vec), .first_err_exp(first_err_exp),
        .done(done), .pass(pass)
    );

    cuasi_result_checker #(.WIDTH(W), .NUM_VEC(7), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .sel(s_sel), .c(s_c),
`ifdef CUASI_CARRY_CHECK_EN
        .cout(s_cout),
`endif
        .chk_valid(s_chk_valid), .mismatch(s_mismatch), .pass_count(s_pass_count),
        .err_count(s_err_count), .first_err_valid(s_first_err_valid),
        .first_err_vec(s_first_err_vec), .first_err_exp(s_first_err_exp),
        .done(s_done), .pass(s_pass)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   m_pass = 0;
    int   m_err = 0;
    vec_t vq[$];
    sb_t  sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] mkvec(input logic [3:0] va, input logic [3:0] vb,
                                            input logic vs, input logic [3:0] vc);
        logic [4:0] s5;
        s5 = {1'b0, va} + {1'b0, vb};
`ifdef CUASI_CARRY_CHECK_EN
        return {va, vb, vs, vc, (vs ? 1'b0 : s5[4])};
`else
        s5 = s5;
        return {va, vb, vs, vc};
`endif
    endfunction

    task automatic put(input int va, input int vb, input int vs, input int vc, input int vbad);
        vec_t v;
        v.a = 4'(va); v.b = 4'(vb); v.sel = 1'(vs); v.c = 4'(vc); v.bad = 1'(vbad);
        vq.push_back(v);
    endtask

    // Scoreboard monitor: every chk_valid must match the oldest pending accept.
    always @(negedge clk) begin
        if (rst_n && chk_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_chk_valid", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                if (e.bad) m_err++; else m_pass++;
                chk("chk_latency", 32'(cyc), 32'(e.due));
                chk("mismatch", 32'(mismatch), 32'(e.bad));
                chk("pass_count_run", 32'(pass_count), 32'(m_pass));
                chk("err_count_run", 32'(err_count), 32'(m_err));
            end
        end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            void'(sbq.pop_front());
            chk("missing_chk_valid", 32'd0, 32'd1);
        end
    end

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m_pass = 0;
        m_err = 0;
        chk("start_clr_pass_count", 32'(pass_count), 32'd0);
        chk("start_clr_err_count", 32'(err_count), 32'd0);
        chk("start_clr_done", 32'(done), 32'd0);
        chk("start_clr_ferr_valid", 32'(first_err_valid), 32'd0);
        chk("start_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send_vecs(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            int guard;
            v = vq[base + i];
            @(negedge clk);
            a = v.a; b = v.b; sel = v.sel; c = v.c; in_valid = 1'b1;
            guard = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                chk("ready_timeout", 32'd0, 32'd1);
            end else begin
                sb_t e;
                e.bad = v.bad;
                e.due = cyc + 2;
                sbq.push_back(e);
            end
        end
    endtask

    // After the last accept: one DRAIN cycle, then DONE with results held against extra in_valid.
    task automatic finish_run(input int e_pass, input int e_err, input int e_ok);
        @(negedge clk);
        a = 4'd7; b = 4'd7; sel = 1'b0; c = 4'd0;
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        chk("drain_done_low", 32'(done), 32'd0);
        @(negedge clk);
        chk("done_rise", 32'(done), 32'd1);
        chk("pass_flag", 32'(pass), 32'(e_ok));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_pass_count", 32'(pass_count), 32'(e_pass));
            chk("done_err_count", 32'(err_count), 32'(e_err));
            chk("done_hold", 32'(done), 32'd1);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // run A: all correct
        put(8,6,0,14,0); put(8,6,1,0,0); put(3,2,0,5,0); put(3,2,1,2,0); put(1,1,0,2,0);
        put(1,1,1,1,0); put(1,5,0,6,0); put(1,5,1,1,0); put(10,2,0,12,0); put(10,2,1,2,0);
        // run B: (3,2,AND) answered with 3
        put(8,6,0,14,0); put(8,6,1,0,0); put(3,2,0,5,0); put(3,2,1,3,1); put(1,1,0,2,0);
        put(1,1,1,1,0); put(1,5,0,6,0); put(1,5,1,1,0); put(10,2,0,12,0); put(10,2,1,2,0);
        // run C: carry-drop cases, two mismatches
        put(10,8,0,2,0); put(10,8,0,0,1); put(15,15,1,15,0); put(15,1,0,0,0); put(1,5,0,7,1);
        put(12,10,1,8,0); put(7,9,0,0,0); put(6,3,1,2,0); put(0,0,0,0,0); put(9,9,0,2,0);
        // run D: aborted by reset after 4 accepts
        put(5,5,0,9,1); put(2,2,1,2,0); put(4,4,0,8,0); put(7,1,1,1,0);

        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass_count", 32'(pass_count), 32'd0);
        chk("rst_chk_valid", 32'(chk_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // IDLE gating
        a = 4'd1; b = 4'd1; sel = 1'b0; c = 4'd2; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 32'd0);
            chk("idle_pass_count", 32'(pass_count), 32'd0);
        end

        start_run(); send_vecs(0, 10); finish_run(10, 0, 1);
        chk("runA_ferr_valid", 32'(first_err_valid), 32'd0);

        start_run(); send_vecs(10, 10); finish_run(9, 1, 0);
        chk("runB_ferr_valid", 32'(first_err_valid), 32'd1);
        chk("runB_ferr_vec", 32'(first_err_vec), 32'(mkvec(4'd3, 4'd2, 1'b1, 4'd3)));
        chk("runB_ferr_exp", 32'(first_err_exp), 32'd2);

        start_run(); send_vecs(20, 10); finish_run(8, 2, 0);
        chk("runC_ferr_vec", 32'(first_err_vec), 32'(mkvec(4'd10, 4'd8, 1'b0, 4'd0)));
        chk("runC_ferr_exp", 32'(first_err_exp), 32'd2);

        // reset mid-run
        start_run(); send_vecs(30, 4);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_ferr_valid", 32'(first_err_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_pass_count", 32'(pass_count), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        chk("arst_ferr_valid", 32'(first_err_valid), 32'd0);
        chk("arst_ferr_vec", 32'(first_err_vec), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        sbq.delete();
        m_pass = 0;
        m_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        start_run(); send_vecs(0, 10); finish_run(10, 0, 1);

        // error counter saturation on a 3-bit, 7-vector instance
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            s_a = 4'(k); s_b = 4'd1; s_sel = 1'b0; s_c = 4'(k + 3); s_in_valid = 1'b1;
            chk("sat_in_ready", 32'(s_in_ready), 32'd1);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) @(negedge clk);
        chk("sat_err_count", 32'(s_err_count), 32'd7);
        chk("sat_pass_count", 32'(s_pass_count), 32'd0);
        chk("sat_done", 32'(s_done), 32'd1);
        chk("sat_pass", 32'(s_pass), 32'd0);
        chk("sat_ferr_vec", 32'(s_first_err_vec), 32'(mkvec(4'd0, 4'd1, 1'b0, 4'd3)));
        chk("sat_ferr_exp", 32'(s_first_err_exp), 32'd1);
        s_in_valid = 1'b0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("sat_restart_err", 32'(s_err_count), 32'd0);
        chk("sat_restart_done", 32'(s_done), 32'd0);
        chk("sat_restart_ferr", 32'(s_first_err_valid), 32'd0);
        chk("sat_restart_ready", 32'(s_in_ready), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
